// File: rtl/vga_pkg.sv
// Shared types for the VGA rectangle animators.
package vga_pkg;

    localparam int POS_W = 12;

    typedef enum logic [1:0] {ST_IDLE, ST_FALL, ST_REST} bounce_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one-cycle tick every CLK_HZ/FRAME_HZ cycles.
module frame_tick_gen #(
    parameter int CLK_HZ   = 65_000_000,
    parameter int FRAME_HZ = 60
) (
    input  logic clk65MHz,
    input  logic rst_n,
    output logic tick
);

    localparam int TICK_DIV = CLK_HZ / FRAME_HZ;
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/draw_rect_bounce_ctl.sv
// Drop-and-bounce controller for the mouse-placed rectangle: tracks the mouse
// when idle, falls under fixed-point gravity on a click, optionally bounces.
module draw_rect_bounce_ctl
    import vga_pkg::*;
#(
    parameter int CLK_HZ       = 65_000_000,
    parameter int FRAME_HZ     = 60,
    parameter int FRAC         = 4,
    parameter int GRAVITY      = 16,
    parameter int V_MAX        = 512,
    parameter int Y_FLOOR      = 704,
    parameter int BOUNCE_SHIFT = 1,
    parameter int V_REST       = 32,
    parameter int REST_TICKS   = 60
) (
    input  logic             clk65MHz,
    input  logic             rst_n,
    input  logic [POS_W-1:0] mouse_xpos,
    input  logic [POS_W-1:0] mouse_ypos,
    input  logic             mouse_left,
    input  logic             mode_bounce,
    input  logic             mode_auto,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             busy
);

    localparam int VW  = FRAC + 13;
    localparam int PW  = POS_W + FRAC + 2;
    localparam int RCW = (REST_TICKS > 1) ? $clog2(REST_TICKS) : 1;

    localparam logic signed [VW-1:0] GRAV_S   = VW'(GRAVITY);
    localparam logic signed [VW-1:0] V_MAX_S  = VW'(V_MAX);
    localparam logic signed [VW-1:0] V_REST_S = VW'(V_REST);
    localparam logic signed [PW-1:0] FLOOR_Q  = PW'(Y_FLOOR << FRAC);

    bounce_state_t state_q, state_d;
    logic                    tick;
    logic                    mouse_left_q;
    logic                    click;
    logic signed [PW-1:0]    pos_q, pos_d, pos_nx, vel_ext;
    logic signed [VW-1:0]    vel_q, vel_d, vel_acc, vel_nx, vel_half;
    logic [POS_W-1:0]        xpos_q, xpos_d, ypos_q, ypos_d;
    logic [RCW-1:0]          rest_q, rest_d;

    frame_tick_gen #(
        .CLK_HZ   (CLK_HZ),
        .FRAME_HZ (FRAME_HZ)
    ) u_tick (
        .clk65MHz (clk65MHz),
        .rst_n    (rst_n),
        .tick     (tick)
    );

    assign click = mouse_left & ~mouse_left_q;

    // Velocity is saturated before it is applied, so the step uses v'.
    always_comb begin
        vel_acc  = vel_q + GRAV_S;
        vel_nx   = (vel_acc > V_MAX_S) ? V_MAX_S : vel_acc;
        vel_ext  = {{(PW-VW){vel_nx[VW-1]}}, vel_nx};
        pos_nx   = pos_q + vel_ext;
        vel_half = vel_nx >>> BOUNCE_SHIFT;
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        vel_d   = vel_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        rest_d  = rest_q;
        case (state_q)
            ST_IDLE: begin
                xpos_d = mouse_xpos;
                ypos_d = mouse_ypos;
                if (click) begin
                    state_d                = ST_FALL;
                    pos_d                  = '0;
                    pos_d[FRAC +: POS_W]   = mouse_ypos;
                    vel_d                  = '0;
                end
            end
            ST_FALL: begin
                if (tick) begin
                    if (pos_nx[PW-1]) begin
                        pos_d = '0;
                        vel_d = '0;
                    end else if (pos_nx >= FLOOR_Q) begin
                        pos_d = FLOOR_Q;
                        if (!mode_bounce || (vel_half < V_REST_S)) begin
                            state_d = ST_REST;
                            vel_d   = '0;
                            rest_d  = '0;
                        end else begin
                            vel_d = -vel_half;
                        end
                    end else begin
                        pos_d = pos_nx;
                        vel_d = vel_nx;
                    end
                end
                ypos_d = pos_d[FRAC +: POS_W];
            end
            ST_REST: begin
                ypos_d = POS_W'(Y_FLOOR);
                if (click) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (rest_q == RCW'(REST_TICKS - 1)) begin
                        if (mode_auto) state_d = ST_IDLE;
                    end else begin
                        rest_d = rest_q + RCW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mouse_left_q <= 1'b0;
            pos_q        <= '0;
            vel_q        <= '0;
            xpos_q       <= '0;
            ypos_q       <= '0;
            rest_q       <= '0;
        end else begin
            state_q      <= state_d;
            mouse_left_q <= mouse_left;
            pos_q        <= pos_d;
            vel_q        <= vel_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            rest_q       <= rest_d;
        end
    end

    assign xpos = xpos_q;
    assign ypos = ypos_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_draw_rect_bounce_ctl.sv
// Directed bench for draw_rect_bounce_ctl: drop, bounce, rest/return, clicks, reset, saturation.
module tb_draw_rect_bounce_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        mouse_left, mouse_left2, mode_bounce, mode_auto;
    logic [11:0] xpos, ypos, xpos2, ypos2;
    logic        busy, busy2;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;

    always #5 clk = ~clk;

    draw_rect_bounce_ctl #(.CLK_HZ(600), .FRAME_HZ(60), .V_MAX(4095)) dut (
        .clk65MHz(clk), .rst_n(rst_n), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .mouse_left(mouse_left), .mode_bounce(mode_bounce), .mode_auto(mode_auto),
        .xpos(xpos), .ypos(ypos), .busy(busy)
    );

    draw_rect_bounce_ctl #(.CLK_HZ(600), .FRAME_HZ(60), .V_MAX(80)) dut_sat (
        .clk65MHz(clk), .rst_n(rst_n), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .mouse_left(mouse_left2), .mode_bounce(mode_bounce), .mode_auto(mode_auto),
        .xpos(xpos2), .ypos(ypos2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edges++;
        #1;
    endtask

    // Tick edges fall on every 10th posedge after reset release.
    task automatic wait_tick();
        do step(); while (edges % 10 != 0);
    endtask

    task automatic click();
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
    endtask

    initial begin
        int e;
        int prev;
        rst_n = 1'b0; mouse_xpos = '0; mouse_ypos = '0; mouse_left = 1'b0; mouse_left2 = 1'b0;
        mode_bounce = 1'b0; mode_auto = 1'b0;
        #12;
        chk("rst_x", xpos, 0); chk("rst_y", ypos, 0); chk("rst_busy", busy, 0);
        do_reset();

        mouse_xpos = 100; mouse_ypos = 50; step();
        chk("track_x", xpos, 100); chk("track_y", ypos, 50); chk("track_busy", busy, 0);

        // plain drop, no bounce, manual return
        mouse_xpos = 200; mouse_ypos = 0; step();
        click();
        chk("drop_busy", busy, 1); chk("drop_x", xpos, 200);
        mouse_xpos = 300;
        for (int n = 1; n <= 37; n++) begin
            wait_tick();
            chk($sformatf("drop_y%0d", n), ypos, n * (n + 1) / 2);
        end
        wait_tick();
        chk("drop_floor", ypos, 704); chk("drop_x_frozen", xpos, 200);
        for (int n = 0; n < 70; n++) wait_tick();
        chk("rest_hold_busy", busy, 1); chk("rest_hold_y", ypos, 704);
        mouse_ypos = 77;
        click();
        chk("rest_click_idle", busy, 0);
        step();
        chk("rest_click_y", ypos, 77); chk("rest_click_x", xpos, 300);

        // bouncing drop
        mode_bounce = 1'b1; mouse_ypos = 0; step();
        click();
        for (int n = 1; n <= 101; n++) begin
            wait_tick();
            case (n)
                1:   e = 1;
                37:  e = 703;
                38:  e = 704;
                39:  e = 686;
                40:  e = 669;
                56:  e = 533;
                74:  e = 686;
                75:  e = 704;
                83:  e = 668;
                98:  e = 701;
                99:  e = 704;
                101: e = 704;
                default: e = -1;
            endcase
            if (e >= 0) chk($sformatf("bounce_y%0d", n), ypos, e);
        end
        chk("bounce_rest_busy", busy, 1);
        click(); step();
        chk("bounce_exit", busy, 0);

        // auto return exactly REST_TICKS after rest entry
        mode_bounce = 1'b0; mode_auto = 1'b1; mouse_xpos = 50; mouse_ypos = 0; step();
        click();
        mouse_xpos = 60; mouse_ypos = 123;
        for (int n = 0; n < 38; n++) wait_tick();
        chk("auto_floor", ypos, 704);
        for (int n = 0; n < 59; n++) wait_tick();
        chk("auto_59_busy", busy, 1);
        wait_tick();
        chk("auto_60_idle", busy, 0);
        step();
        chk("auto_y", ypos, 123); chk("auto_x", xpos, 60);
        mode_auto = 1'b0;

        // held button gives a single drop
        mouse_xpos = 10; mouse_ypos = 0; step();
        mouse_left = 1'b1;
        repeat (500) step();
        chk("held_busy", busy, 1); chk("held_y", ypos, 704);
        mouse_left = 1'b0; step(); step();
        chk("release_busy", busy, 1);
        click(); step();
        chk("held_exit", busy, 0);

        // clicks during the fall are ignored
        click();
        for (int n = 1; n <= 38; n++) begin
            wait_tick();
            chk($sformatf("pulse_y%0d", n), ypos, (n == 38) ? 704 : n * (n + 1) / 2);
            if (n < 38) begin
                mouse_left = 1'b1; step();
                mouse_left = 1'b0; step();
            end
        end
        chk("pulse_busy", busy, 1);
        click(); step();

        // async reset mid-fall
        click();
        for (int n = 0; n < 5; n++) wait_tick();
        chk("midfall_y", ypos, 15);
        #3 rst_n = 1'b0;
        #1;
        chk("async_x", xpos, 0); chk("async_y", ypos, 0); chk("async_busy", busy, 0);
        mouse_xpos = 100; mouse_ypos = 50;
        do_reset();
        step();
        chk("post_rst_x", xpos, 100); chk("post_rst_y", ypos, 50); chk("post_rst_busy", busy, 0);

        // velocity saturation at 5 px/tick on the second instance
        mouse_ypos = 0; step();
        mouse_left2 = 1'b1; step(); mouse_left2 = 1'b0;
        chk("sat_busy", busy2, 1);
        prev = 0;
        for (int n = 1; n <= 12; n++) begin
            wait_tick();
            chk($sformatf("sat_y%0d", n), ypos2, (n <= 5) ? n * (n + 1) / 2 : 15 + 5 * (n - 5));
            chk($sformatf("sat_step%0d", n), ((int'(ypos2) - prev) <= 5), 1);
            prev = int'(ypos2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
